// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues PC-ordered reads to a 1-cycle synchronous IMEM, buffers returns
// in a prefetch FIFO and feeds the IF/ID register. Optional perf counters: define IF_PERF_CNT_EN.
`timescale 1ns/1ps
module if_fetch_unit #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_IF_out,
    output logic [31:0] pc_IF_out,
    output logic        valid_out,
    output logic        stop_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_out,
    output logic [31:0] stall_cnt_out
`endif
);
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [31:0] PC_END = 32'(IMEM_WORDS * 4);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic          rd_vld_p1;
    logic [31:0]   rd_pc_p1;
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW+1:0] occ;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          marker;

    // Reads returning after the end marker belong to the next program slot and are discarded.
    assign fifo_empty = (count == '0);
    assign occ        = {1'b0, count} + (AW+2)'(rd_vld_p1);
    assign imem_req   = (state == S_RUN) && (occ < (AW+2)'(FIFO_DEPTH)) && (pc < PC_END);
    assign imem_addr  = pc;
    assign push       = rd_vld_p1 && (state == S_RUN) && (imem_rdata != 32'h0);
    assign marker     = rd_vld_p1 && (state == S_RUN) && (imem_rdata == 32'h0);
    assign pop        = !stall_in && !fifo_empty && (state != S_HALT);

    // Stage p0 -> p1: issue, capture PC of the in-flight read
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            pc          <= PC_RESET;
            rd_vld_p1   <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            inst_IF_out <= '0;
            pc_IF_out   <= '0;
            valid_out   <= 1'b0;
            stop_out    <= 1'b0;
        end else begin
            rd_vld_p1 <= imem_req;
            if (imem_req)
                pc <= pc + 32'd4;

            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            case (state)
                S_RUN: begin
                    if (marker || ((pc >= PC_END) && !rd_vld_p1))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (fifo_empty && !stall_in)
                        state <= S_HALT;
                end
                default: state <= S_HALT;
            endcase

            // Stage p1 -> p2: FIFO head to the IF/ID register
            if (state == S_HALT) begin
                inst_IF_out <= '0;
                valid_out   <= 1'b0;
                stop_out    <= 1'b1;
            end else if (!stall_in) begin
                if (!fifo_empty) begin
                    inst_IF_out <= fifo_inst[rd_ptr];
                    pc_IF_out   <= fifo_pc[rd_ptr];
                    valid_out   <= 1'b1;
                end else begin
                    inst_IF_out <= '0;
                    valid_out   <= 1'b0;
                    if (state == S_DRAIN)
                        stop_out <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req)
            rd_pc_p1 <= pc;
        if (push) begin
            fifo_inst[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= rd_pc_p1;
        end
    end

`ifdef IF_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_out <= '0;
            stall_cnt_out <= '0;
        end else begin
            if (pop)
                fetch_cnt_out <= sat_inc(fetch_cnt_out);
            if (stall_in && !fifo_empty)
                stall_cnt_out <= sat_inc(stall_cnt_out);
        end
    end
`endif

endmodule
